// File: rtl/commit_ras_restore_if.sv
// Opcode type plus the commit/restore bundle shared by commit_ras_restore and its frontend peer.
// The slave modport is the commit-side RAS; master is the ROB/frontend side.
package commit_ras_pkg;
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } rv32i_op_t;
endpackage

interface commit_ras_if #(
  parameter int PTR_WIDTH = 5
);
  logic                          commit_valid;
  logic                          commit_ready;
  commit_ras_pkg::rv32i_op_t     commit_opcode;
  logic [4:0]                    commit_rd;
  logic [4:0]                    commit_rs1;
  logic [31:0]                   commit_link;
  logic                          flush_req;
  logic                          restore_valid;
  logic                          restore_ready;
  logic [PTR_WIDTH-1:0]          restore_idx;
  logic [31:0]                   restore_data;
  logic                          restore_done;
  logic [PTR_WIDTH-1:0]          restore_ptr;
  logic                          busy;

  modport slave (
    input  commit_valid, commit_opcode, commit_rd, commit_rs1, commit_link,
    input  flush_req, restore_ready,
    output commit_ready, restore_valid, restore_idx, restore_data,
    output restore_done, restore_ptr, busy
  );

  modport master (
    output commit_valid, commit_opcode, commit_rd, commit_rs1, commit_link,
    output flush_req, restore_ready,
    input  commit_ready, restore_valid, restore_idx, restore_data,
    input  restore_done, restore_ptr, busy
  );
endinterface

// File: rtl/commit_ras_restore.sv
// Commit-side return address stack that replays its contents into the frontend RAS on a flush.
// Define COMMIT_RAS_WRAP_EN for a circular stack that overwrites the oldest entry when full.
module commit_ras_restore #(
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  commit_ras_if.slave   bus
);
  import commit_ras_pkg::*;

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH-1:0] ONE      = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] ZERO     = PTR_WIDTH'(0);
  localparam logic [PTR_WIDTH-1:0] FULL_CNT = PTR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTORE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0] snap_q, snap_d;
  logic [PTR_WIDTH-1:0] idx_q, idx_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic                 done_q, done_d;
  logic [PTR_WIDTH-1:0] base_s, base_nxt_s;
  logic [PTR_WIDTH-1:0] count_s, count_post_s;
  logic                 fire_s, push_s, pop_s, wr_en_s;
  logic [31:0]          stack_q [DEPTH];

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

`ifdef COMMIT_RAS_WRAP_EN
  logic [PTR_WIDTH-1:0] base_q, base_d;
  assign base_s     = base_q;
  assign base_nxt_s = base_d;
`else
  assign base_s     = ZERO;
  assign base_nxt_s = ZERO;
`endif

  assign fire_s  = bus.commit_valid && (state_q == ST_IDLE);
  assign push_s  = fire_s && ((bus.commit_opcode == OP_JAL) || (bus.commit_opcode == OP_JALR))
                   && is_link(bus.commit_rd);
  assign pop_s   = fire_s && (bus.commit_opcode == OP_JALR) && !is_link(bus.commit_rd)
                   && is_link(bus.commit_rs1);
  assign count_s = ptr_q - base_s;
  assign count_post_s = ptr_d - base_nxt_s;

  // Retired call/return pointer update; a flush in the same cycle sees the result.
  always_comb begin
    ptr_d   = ptr_q;
    wr_en_s = 1'b0;
`ifdef COMMIT_RAS_WRAP_EN
    base_d  = base_q;
`endif
    if (push_s) begin
      if (count_s != FULL_CNT) begin
        ptr_d   = ptr_q + ONE;
        wr_en_s = 1'b1;
      end else begin
`ifdef COMMIT_RAS_WRAP_EN
        ptr_d   = ptr_q + ONE;
        base_d  = base_q + ONE;
        wr_en_s = 1'b1;
`else
        ptr_d   = ptr_q;
`endif
      end
    end else if (pop_s) begin
      if (count_s != ZERO) begin
        ptr_d = ptr_q - ONE;
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Restore FSM: snapshot, stream beats, then a registered done pulse.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    rptr_d  = ZERO;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush_req) begin
          snap_d  = count_post_s;
          idx_d   = ZERO;
          state_d = (count_post_s != ZERO) ? ST_RESTORE : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESTORE: begin
        if (bus.flush_req) begin
          idx_d   = ZERO;
          state_d = (snap_q != ZERO) ? ST_RESTORE : ST_DONE;
        end else if (bus.restore_ready) begin
          if (idx_q == (snap_q - ONE)) begin
            idx_d   = ZERO;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ONE;
          end
        end else begin
          state_d = ST_RESTORE;
        end
      end
      ST_DONE: begin
        if (bus.flush_req) begin
          idx_d   = ZERO;
          state_d = (snap_q != ZERO) ? ST_RESTORE : ST_DONE;
        end else begin
          done_d  = 1'b1;
          rptr_d  = snap_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= ZERO;
      snap_q  <= ZERO;
      idx_q   <= ZERO;
      done_q  <= 1'b0;
      rptr_q  <= ZERO;
`ifdef COMMIT_RAS_WRAP_EN
      base_q  <= ZERO;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rptr_q  <= rptr_d;
`ifdef COMMIT_RAS_WRAP_EN
      base_q  <= base_d;
`endif
    end
  end

  // Stack storage has no reset; slots are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      stack_q[ptr_q] <= bus.commit_link;
    end
  end

  assign bus.commit_ready  = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.restore_valid = (state_q == ST_RESTORE);
  assign bus.restore_idx   = idx_q;
  assign bus.restore_data  = stack_q[base_s + idx_q];
  assign bus.restore_done  = done_q;
  assign bus.restore_ptr   = rptr_q;
endmodule

// File: tb/tb_commit_ras_restore.sv
// Scenario bench for commit_ras_restore: a stack model feeds a beat scoreboard drained by a monitor.
module tb_commit_ras_restore;
  import commit_ras_pkg::*;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_ras_if #(.PTR_WIDTH(5)) bus ();
  commit_ras_restore #(.DEPTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];
  logic [31:0] model_q[$];
  int done_cnt = 0;
  int beat_cnt = 0;
  int pass_beats = 0;
  logic [31:0] first_data, last_data;
  logic stall_prev = 1'b0;
  beat_t stall_beat, mon_e;

  // Monitor: scoreboard every accepted beat, check stalled beats hold, count done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (bus.restore_valid !== 1'b1 || bus.restore_idx !== stall_beat.idx ||
            bus.restore_data !== stall_beat.data) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b idx=%0d data=%h want idx=%0d data=%h",
                   bus.restore_valid, bus.restore_idx, bus.restore_data, stall_beat.idx, stall_beat.data);
        end
      end
      stall_prev = 1'b0;
      if (bus.restore_valid === 1'b1) begin
        if (bus.restore_ready === 1'b1) begin
          beat_cnt++;
          if (pass_beats == 0) first_data = bus.restore_data;
          last_data = bus.restore_data;
          pass_beats++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got idx=%0d data=%h want no beat", bus.restore_idx, bus.restore_data);
          end else begin
            mon_e = exp_q.pop_front();
            if (bus.restore_idx !== mon_e.idx || bus.restore_data !== mon_e.data) begin
              errors++;
              $display("FAIL beat: got idx=%0d data=%h want idx=%0d data=%h",
                       bus.restore_idx, bus.restore_data, mon_e.idx, mon_e.data);
            end
          end
        end else if (bus.flush_req !== 1'b1) begin
          stall_prev = 1'b1;
          stall_beat = '{idx: bus.restore_idx, data: bus.restore_data};
        end
      end
      if (bus.restore_done === 1'b1) begin
        done_cnt++;
      end
    end
  end

  function automatic bit tb_is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_expect();
    exp_q.delete();
    for (int i = 0; i < model_q.size(); i++) begin
      exp_q.push_back('{idx: 5'(i), data: model_q[i]});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_opcode = OP_IMM;
    bus.commit_rd = 5'd0;
    bus.commit_rs1 = 5'd0;
    bus.commit_link = 32'd0;
    bus.flush_req = 1'b0;
    bus.restore_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_q.delete();
    exp_q.delete();
  endtask

  task automatic commit(input rv32i_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [31:0] link, input bit with_flush);
    bus.commit_valid = 1'b1;
    bus.commit_opcode = op;
    bus.commit_rd = rd;
    bus.commit_rs1 = rs1;
    bus.commit_link = link;
    bus.flush_req = with_flush;
    if ((op == OP_JAL || op == OP_JALR) && tb_is_link(rd)) begin
      if (model_q.size() < 31) begin
        model_q.push_back(link);
      end else begin
`ifdef COMMIT_RAS_WRAP_EN
        void'(model_q.pop_front());
        model_q.push_back(link);
`endif
      end
    end else if (op == OP_JALR && tb_is_link(rs1)) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
    end
    if (with_flush) begin
      pass_beats = 0;
      load_expect();
    end
    tick();
    bus.commit_valid = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic flush_only();
    bus.flush_req = 1'b1;
    pass_beats = 0;
    load_expect();
    tick();
    bus.flush_req = 1'b0;
  endtask

  // Counts edges from the flush edge until restore_done is seen, bounded by budget.
  task automatic wait_done(input int budget, output int lat, output bit ok);
    ok = 1'b0;
    lat = 1;
    for (int i = 0; i < budget; i++) begin
      if (bus.restore_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.restore_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.restore_valid); end
    checks++; if (bus.restore_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.restore_done); end
    checks++; if (bus.restore_idx !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.restore_idx); end
    checks++; if (bus.restore_ptr !== 5'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", bus.restore_ptr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.commit_ready !== 1'b1) begin errors++; $display("FAIL reset_commit_ready: got %b want 1", bus.commit_ready); end
  endtask

  task automatic test_empty_flush();
    int lat; bit ok;
    flush_only();
    checks++; if (bus.busy !== 1'b1 || bus.restore_valid !== 1'b0) begin errors++; $display("FAIL empty_state: got busy=%b valid=%b want busy=1 valid=0", bus.busy, bus.restore_valid); end
    wait_done(10, lat, ok);
    checks++; if (!ok || lat != 2) begin errors++; $display("FAIL empty_latency: got ok=%0b lat=%0d want ok=1 lat=2", ok, lat); end
    checks++; if (bus.restore_ptr !== 5'd0) begin errors++; $display("FAIL empty_ptr: got %0d want 0", bus.restore_ptr); end
    tick();
    checks++; if (bus.restore_done !== 1'b0 || bus.commit_ready !== 1'b1) begin errors++; $display("FAIL empty_after: got done=%b ready=%b want done=0 ready=1", bus.restore_done, bus.commit_ready); end
  endtask

  task automatic test_two_push();
    int lat; bit ok; int d0;
    commit(OP_JAL, 5'd1, 5'd0, 32'h100, 1'b0);
    commit(OP_JAL, 5'd2, 5'd0, 32'h150, 1'b0);
    commit(OP_JAL, 5'd5, 5'd0, 32'h200, 1'b0);
    d0 = done_cnt;
    flush_only();
    wait_done(20, lat, ok);
    checks++; if (!ok || lat != model_q.size() + 2) begin errors++; $display("FAIL two_latency: got ok=%0b lat=%0d want ok=1 lat=%0d", ok, lat, model_q.size() + 2); end
    checks++; if (bus.restore_ptr !== 5'd2) begin errors++; $display("FAIL two_ptr: got %0d want 2", bus.restore_ptr); end
    tick();
    checks++; if (exp_q.size() != 0 || done_cnt - d0 != 1) begin errors++; $display("FAIL two_drain: got left=%0d dones=%0d want left=0 dones=1", exp_q.size(), done_cnt - d0); end
  endtask

  task automatic test_pop_with_flush();
    int lat; bit ok;
    do_reset();
    commit(OP_JAL, 5'd1, 5'd0, 32'h100, 1'b0);
    commit(OP_JALR, 5'd5, 5'd3, 32'h200, 1'b0);
    commit(OP_JALR, 5'd0, 5'd1, 32'h0, 1'b1);
    wait_done(20, lat, ok);
    checks++; if (!ok || lat != 3) begin errors++; $display("FAIL pop_latency: got ok=%0b lat=%0d want ok=1 lat=3", ok, lat); end
    checks++; if (bus.restore_ptr !== 5'd1) begin errors++; $display("FAIL pop_ptr: got %0d want 1", bus.restore_ptr); end
    tick();
    checks++; if (exp_q.size() != 0 || pass_beats != 1) begin errors++; $display("FAIL pop_drain: got left=%0d beats=%0d want left=0 beats=1", exp_q.size(), pass_beats); end
  endtask

  task automatic test_stall();
    int lat; bit ok;
    logic [4:0] pat;
    do_reset();
    pat = 5'b11001;
    for (int i = 0; i < 3; i++) commit(OP_JALR, 5'd1, 5'd2, 32'h400 + 32'(i * 16), 1'b0);
    flush_only();
    for (int k = 0; k < 5; k++) begin
      bus.restore_ready = pat[4 - k];
      checks++; if (bus.commit_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL stall_commit_ready: got ready=%b busy=%b want ready=0 busy=1 (cycle %0d)", bus.commit_ready, bus.busy, k); end
      tick();
    end
    bus.restore_ready = 1'b1;
    wait_done(20, lat, ok);
    checks++; if (!ok || bus.restore_ptr !== 5'd3) begin errors++; $display("FAIL stall_done: got ok=%0b ptr=%0d want ok=1 ptr=3", ok, bus.restore_ptr); end
    tick();
    checks++; if (pass_beats != 3 || exp_q.size() != 0) begin errors++; $display("FAIL stall_beats: got beats=%0d left=%0d want beats=3 left=0", pass_beats, exp_q.size()); end
  endtask

  task automatic test_abort();
    int lat; bit ok; int d0; int b0;
    do_reset();
    for (int i = 0; i < 3; i++) commit(OP_JAL, 5'd5, 5'd0, 32'h3000 + 32'(i * 4), 1'b0);
    d0 = done_cnt;
    b0 = beat_cnt;
    flush_only();
    tick();
    bus.restore_ready = 1'b0;
    flush_only();
    checks++; if (bus.restore_idx !== 5'd0 || bus.restore_valid !== 1'b1) begin errors++; $display("FAIL abort_restart: got idx=%0d valid=%b want idx=0 valid=1", bus.restore_idx, bus.restore_valid); end
    bus.restore_ready = 1'b1;
    wait_done(20, lat, ok);
    checks++; if (!ok || bus.restore_ptr !== 5'd3) begin errors++; $display("FAIL abort_done: got ok=%0b ptr=%0d want ok=1 ptr=3", ok, bus.restore_ptr); end
    tick();
    tick();
    checks++; if (done_cnt - d0 != 1 || beat_cnt - b0 != 4 || exp_q.size() != 0) begin errors++; $display("FAIL abort_counts: got dones=%0d beats=%0d left=%0d want dones=1 beats=4 left=0", done_cnt - d0, beat_cnt - b0, exp_q.size()); end
  endtask

  task automatic test_fill();
    int lat; bit ok;
    logic [31:0] want_first, want_last;
    do_reset();
`ifdef COMMIT_RAS_WRAP_EN
    want_first = 32'h1024;
    want_last = 32'h109C;
`else
    want_first = 32'h1000;
    want_last = 32'h1078;
`endif
    for (int i = 0; i < 40; i++) commit(OP_JAL, 5'd1, 5'd0, 32'h1000 + 32'(4 * i), 1'b0);
    flush_only();
    wait_done(100, lat, ok);
    checks++; if (!ok || bus.restore_ptr !== 5'd31 || lat != 33) begin errors++; $display("FAIL fill_done: got ok=%0b ptr=%0d lat=%0d want ok=1 ptr=31 lat=33", ok, bus.restore_ptr, lat); end
    tick();
    checks++; if (first_data !== want_first || last_data !== want_last || pass_beats != 31) begin errors++; $display("FAIL fill_data: got first=%h last=%h beats=%0d want first=%h last=%h beats=31", first_data, last_data, pass_beats, want_first, want_last); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) commit(OP_JAL, 5'd1, 5'd0, 32'h500 + 32'(i * 4), 1'b0);
    flush_only();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.restore_valid !== 1'b0 || bus.busy !== 1'b0 || bus.commit_ready !== 1'b1) begin errors++; $display("FAIL reset_mid: got valid=%b busy=%b ready=%b want valid=0 busy=0 ready=1", bus.restore_valid, bus.busy, bus.commit_ready); end
    checks++; if (bus.restore_idx !== 5'd0 || bus.restore_done !== 1'b0) begin errors++; $display("FAIL reset_mid_idx: got idx=%0d done=%b want idx=0 done=0", bus.restore_idx, bus.restore_done); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_empty_flush();
    test_two_push();
    test_pop_with_flush();
    test_stall();
    test_abort();
    test_fill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
